// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between a core iBus/dBus master and a word-addressed slave.
interface wb_ram_slave_if;
  logic [29:0] ADR;
  logic [31:0] DAT_MOSI;
  logic [3:0]  SEL;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [31:0] DAT_MISO;
  logic        ACK;
  logic        ERR;

  modport master (
    output ADR, DAT_MOSI, SEL, CYC, STB, WE,
    input  DAT_MISO, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_MOSI, SEL, CYC, STB, WE,
    output DAT_MISO, ACK, ERR
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave: word-addressed, byte-lane writes, fixed wait states.
// Define WB_RAM_RANDOM_WAIT_EN to draw each wait count from an LFSR, capped at MAX_WAIT.
module wb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int unsigned WAIT_CYCLES = 1
`ifdef WB_RAM_RANDOM_WAIT_EN
  ,
  parameter int unsigned MAX_WAIT    = 3
`endif
) (
  input logic           clock,
  input logic           reset_n,
  wb_ram_slave_if.slave wb
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d, wait_load;
  logic [ADDR_WIDTH-1:0]   idx_q, req_idx;
  logic [31:0]             dat_q, miso_q;
  logic [3:0]              sel_q;
  logic                    we_q, in_range_q;
  logic                    bus_in_range, req_in_range, start, enter_resp;
  logic [31:0]             mem [Depth];

  assign bus_in_range = (wb.ADR[29:ADDR_WIDTH] == BASE_ADDR[29:ADDR_WIDTH]);
  assign start        = (state_q == StIdle) && wb.CYC && wb.STB;
  assign enter_resp   = (state_d == StResp) && (state_q != StResp);

  // A zero-wait request enters RESP straight from IDLE, before the latch is visible.
  assign req_idx      = (state_q == StIdle) ? wb.ADR[ADDR_WIDTH-1:0] : idx_q;
  assign req_in_range = (state_q == StIdle) ? bus_in_range : in_range_q;
  logic req_we;
  assign req_we       = (state_q == StIdle) ? wb.WE : we_q;

`ifdef WB_RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr_q;
  logic [3:0] lfsr_wait;

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lfsr_wait = {1'b0, lfsr_q[2:0]};
  assign wait_load = (lfsr_wait > 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : lfsr_wait;
`else
  assign wait_load = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = wait_load;
          state_d = (wait_load != 4'd0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (!wb.CYC) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        if (!req_in_range)  miso_q <= '0;
        else if (!req_we)   miso_q <= mem[req_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      idx_q      <= wb.ADR[ADDR_WIDTH-1:0];
      we_q       <= wb.WE;
      sel_q      <= wb.SEL;
      dat_q      <= wb.DAT_MOSI;
      in_range_q <= bus_in_range;
    end
  end

  // Commit on the edge leaving RESP only if the master still owns the cycle.
  always_ff @(posedge clock) begin
    if (reset_n && (state_q == StResp) && we_q && in_range_q && wb.CYC) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end

  assign wb.DAT_MISO = miso_q;
  assign wb.ACK      = (state_q == StResp) && in_range_q && wb.CYC;
  assign wb.ERR      = (state_q == StResp) && !in_range_q && wb.CYC;

endmodule
